// File: rtl/const_seq_pkg.sv
// Shared types and helpers for the const_seq constant-sequence source.
package const_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int unsigned PASS_W = 16;

  // Index width for a table of the given depth; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/const_seq_if.sv
// Handshake/bus bundle between const_seq (master) and its consumer (slave).
interface const_seq_if
  import const_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned IDX_W = idx_width(DEPTH);

  logic              start;
  logic              loop;
  logic              ready;
  logic              valid;
  logic [WIDTH-1:0]  y;
  logic [IDX_W-1:0]  idx;
  logic              done;
  logic [PASS_W-1:0] passes;

  modport master (
    input  start, loop, ready,
    output valid, y, idx, done, passes
  );

  modport slave (
    output start, loop, ready,
    input  valid, y, idx, done, passes
  );

endinterface

// File: rtl/const_seq_rom.sv
// Combinational lookup of one WIDTH-bit entry from the packed constant table.
module const_seq_rom #(
  parameter int unsigned               WIDTH = 8,
  parameter int unsigned               DEPTH = 4,
  parameter logic [DEPTH*WIDTH-1:0]    TABLE = {8'd9, 8'd7, 8'd5, 8'd3},
  parameter int unsigned               IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [WIDTH-1:0] data_o
);

  // Out-of-range indices (non-power-of-two DEPTH) read as zero.
  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (idx_i == IDX_W'(i)) data_o = TABLE[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/const_seq.sv
// Constant-sequence source: plays a DEPTH-entry table over valid/ready.
// Define CONST_SEQ_LOOP_EN to honour the loop input (wrap instead of finishing).
module const_seq
  import const_seq_pkg::*;
#(
  parameter int unsigned            WIDTH    = 8,
  parameter int unsigned            DEPTH    = 4,
  parameter logic [DEPTH*WIDTH-1:0] TABLE    = {8'd9, 8'd7, 8'd5, 8'd3},
  parameter logic [WIDTH-1:0]       IDLE_VAL = 8'd3
) (
  input logic         clock,
  input logic         reset,
  const_seq_if.master bus
);

  localparam int unsigned      IDX_W    = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef CONST_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [WIDTH-1:0]  rom_data;

  // The ROM is addressed by the next index so y can be registered alongside it.
  const_seq_rom #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TABLE (TABLE),
    .IDX_W (IDX_W)
  ) u_rom (
    .idx_i  (idx_d),
    .data_o (rom_data)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    passes_d = passes_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.ready) begin
          if (idx_q == LAST_IDX) begin
            passes_d = passes_q + PASS_W'(1);
            idx_d    = '0;
            if (!(LOOP_EN && bus.loop)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    valid_d = (state_d == ST_RUN);
    y_d     = valid_d ? rom_data : IDLE_VAL;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      y_q      <= IDLE_VAL;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      passes_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      passes_q <= passes_d;
    end
  end

  assign bus.valid  = valid_q;
  assign bus.y      = y_q;
  assign bus.idx    = idx_q;
  assign bus.done   = done_q;
  assign bus.passes = passes_q;

endmodule

// File: doc/const_seq.md
# const_seq

Parametrised constant-sequence source, successor to the fixed single-value constant blocks (`const_i8` and its siblings). It emits a compile-time table of `DEPTH` constants of `WIDTH` bits, one entry per accepted transfer, over a valid/ready handshake. It supports one-shot playback and, when configured, continuous looping. It sits at the edge of generated datapaths as a stimulus or coefficient feeder.

## Interface
- `WIDTH`, default 8: bits per constant.
- `DEPTH`, default 4: number of table entries; must be ≥ 1.
- `TABLE`, default {8'd9, 8'd7, 8'd5, 8'd3}: packed `DEPTH*WIDTH` table. Entry i is `TABLE[i*WIDTH +: WIDTH]`, so entry 0 sits in the LSBs.
- `IDLE_VAL`, default 8'd3: value driven on `y` while not running.
- `clock`, input, 1: clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: begin playback; sampled only in IDLE.
- `loop`, input, 1: wrap to entry 0 after the last entry instead of finishing. Used only when `CONST_SEQ_LOOP_EN` is defined.
- `ready`, input, 1: consumer accepts `y` this cycle.
- `valid`, output, 1: `y` holds a table entry.
- `y`, output, WIDTH: current constant.
- `idx`, output, clog2(DEPTH) (min 1): index of the current entry.
- `done`, output, 1: one-cycle pulse after the last entry is accepted.
- `passes`, output, 16: count of completed full passes; wraps modulo 2^16.

## Operation
- State machine:
  - IDLE. `valid`=0, `y`=`IDLE_VAL`, `idx`=0. `start`=1 moves to RUN.
  - RUN. `valid`=1, `y`=`TABLE[idx]`.
    - A transfer happens when `valid` & `ready`.
    - Transfer with `idx` < `DEPTH`-1: `idx` increments.
    - Transfer with `idx`=`DEPTH`-1: `passes` increments. If looping (macro defined and `loop`=1), `idx`←0 and the block stays in RUN. Otherwise it moves to DONE.
  - DONE. `valid`=0, `y`=`IDLE_VAL`, `done`=1. Unconditionally returns to IDLE next cycle.
- `loop` is sampled at the final-entry transfer only. Deasserting it mid-pass finishes the current pass.
- `start` is ignored outside IDLE. `start` in the DONE cycle is ignored; a new start must arrive in IDLE.
- `ready` low stalls: `y`, `idx` and `valid` hold stable until the transfer.
- `DEPTH`=1: every transfer is a final-entry transfer.
- Reset values: state IDLE, `valid`=0, `y`=`IDLE_VAL`, `idx`=0, `done`=0, `passes`=0.
- Reset mid-operation aborts with no `done` pulse. `passes` clears.

## Timing
- Outputs are registered; there is no combinational path from inputs to outputs.
- `start` high at edge N (in IDLE) gives `valid`=1 and `y`=entry 0 after edge N.
- Throughput is one entry per cycle with `ready` held high.
- The final transfer at edge M gives `done`=1 for the cycle after M, then IDLE.
- A one-shot pass therefore takes `DEPTH`+1 cycles from start to return to IDLE, with `ready` high.
- When looping, entry 0 follows entry `DEPTH`-1 on the next cycle with no bubble.
- `passes` updates on the same edge as the final transfer.

## Configuration
- `CONST_SEQ_LOOP_EN` defined: the `loop` input is honoured as described under Operation.
- Undefined: the `loop` port stays in the port list but is ignored. Every pass ends in DONE, and the wrap logic is not synthesised.

## Structure
- Package `const_seq_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the `PASS_W`=16 constant;
  - an index-width function (clog2, min 1).
- One sub-module, `const_seq_rom`: a combinational `TABLE` lookup by `idx`, registered in the parent. All control logic stays in `const_seq`.

## Test plan
All scenarios use the defaults (entries 3, 5, 7, 9) unless stated.
- Reset held 16 cycles → `valid`=0, `y`=3, `idx`=0, `passes`=0, `done`=0 throughout.
- One-shot: `start` pulse, `ready`=1 → `y`=3, 5, 7, 9 on consecutive cycles; `done` pulses the next cycle; `passes`=1; back to IDLE with `y`=3.
- Backpressure: `ready`=0 for 3 cycles on entry 1 → `y`=5 stays stable with `valid`=1, then sequence continues 7, 9; total 7 cycles from start to `done`.
- Loop (macro on): `loop`=1 for 10 transfers → `y`=3, 5, 7, 9, 3, 5, 7, 9, 3, 5 with no `done`; `passes`=2. Drop `loop` → pass finishes at 9, then `done`. Macro off: same stimulus ends after 9 with `done`.
- `start` pulsed during RUN and during the DONE cycle → ignored; exactly one pass; `passes`=1.
- Reset asserted at entry 7 → next cycle IDLE, `y`=3, `valid`=0, no `done`, `passes`=0. `DEPTH`=1, `TABLE`=8'd42: each pass emits one beat of 42.
